// File: rtl/ascon_block_sequencer_pkg.sv
// ============================================================================
// Module      : ascon_block_sequencer_pkg
// Description : Shared state encoding and region constants for the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ascon_block_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_AD      = 3'd1,
    S_DATA    = 3'd2,
    S_WAIT_CT = 3'd3,
    S_DONE    = 3'd4
  } seq_state_t;

  localparam logic [7:0] PAD_BYTE  = 8'h80;
  localparam int         c_ad_base = 0;

  // Data region sits directly after the AD region in the window.
  function automatic int data_base(input int ad_words);
    return c_ad_base + ad_words;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ascon_block_sequencer_if.sv
// ============================================================================
// Module      : ascon_block_sequencer_if
// Description : Memory-window, block and control signals of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ascon_block_sequencer_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] wb_addr_i;
  logic [31:0]       wb_wdata_i;
  logic              mem_we_ni;
  logic [31:0]       mem_rdata_o;
  logic              start_i;
  logic [4:0]        ad_len_i;
  logic [7:0]        data_len_i;
  logic [63:0]       blk_data_o;
  logic              blk_valid_o;
  logic              blk_ready_i;
  logic              blk_is_ad_o;
  logic              blk_last_o;
  logic [3:0]        blk_bytes_o;
  logic [63:0]       ct_data_i;
  logic              ct_valid_i;
  logic              busy_o;
  logic              done_o;
  logic              len_err_o;

  modport slave (
    input  wb_addr_i, wb_wdata_i, mem_we_ni, start_i, ad_len_i, data_len_i,
           blk_ready_i, ct_data_i, ct_valid_i,
    output mem_rdata_o, blk_data_o, blk_valid_o, blk_is_ad_o, blk_last_o,
           blk_bytes_o, busy_o, done_o, len_err_o
  );

  modport master (
    output wb_addr_i, wb_wdata_i, mem_we_ni, start_i, ad_len_i, data_len_i,
           blk_ready_i, ct_data_i, ct_valid_i,
    input  mem_rdata_o, blk_data_o, blk_valid_o, blk_is_ad_o, blk_last_o,
           blk_bytes_o, busy_o, done_o, len_err_o
  );
endinterface

`default_nettype wire

// File: rtl/ascon_block_sequencer_pad.sv
// ============================================================================
// Module      : ascon_pad_unit
// Description : Combinational 10*-style padding of one 64-bit block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascon_pad_unit
  import ascon_block_sequencer_pkg::*;
(
  input  logic [63:0] i_raw,
  input  logic [7:0]  i_rem,
  output logic [63:0] o_padded,
  output logic [3:0]  o_bytes,
  output logic [7:0]  o_mask
);

  for (genvar j = 0; j < 8; j++) begin : g_byte
    assign o_mask[j] = i_rem > 8'(j);
    assign o_padded[63-8*j -: 8] = o_mask[j]       ? i_raw[63-8*j -: 8] :
                                   (i_rem == 8'(j)) ? PAD_BYTE : 8'h00;
  end

  assign o_bytes = (i_rem >= 8'd8) ? 4'd8 : i_rem[3:0];

endmodule

`default_nettype wire

// File: rtl/ascon_block_sequencer.sv
// ============================================================================
// Module      : ascon_block_sequencer
// Description : Message buffer; streams padded AD/data blocks to the ASCON
//               core and writes processed data blocks back in place.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascon_block_sequencer
  import ascon_block_sequencer_pkg::*;
#(
  parameter int AD_WORDS   = 8,
  parameter int DATA_WORDS = 24,
  parameter int ADDR_W     = 5
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  ascon_block_sequencer_if.slave bus
);

  localparam int               c_total     = AD_WORDS + DATA_WORDS;
  localparam int               c_aw        = ADDR_W + 1;
  localparam int               c_idx_w     = $clog2(DATA_WORDS/2 + 1);
  localparam logic [c_aw-1:0]  c_total_a   = c_aw'(c_total);
  localparam logic [c_aw-1:0]  c_data_base = c_aw'(data_base(AD_WORDS));
  localparam logic [8:0]       c_data_max  = 9'(4*DATA_WORDS);

  seq_state_t           r_state, w_state_nx;
  logic [7:0]           r_rem, w_rem_nx;
  logic [7:0]           r_data_len, w_data_len_nx;
  logic [c_idx_w-1:0]   r_idx, w_idx_nx;
  logic                 r_len_err, w_len_err_nx;
  logic [31:0]          r_buf [c_total];
  logic [31:0]          r_rdata;

  logic                 w_busy, w_is_ad, w_valid, w_accept, w_last;
  logic                 w_host_we, w_wb_en, w_clamp;
  logic [7:0]           w_dlen_c;
  logic [c_aw-1:0]      w_addr_hi, w_addr_lo;
  logic [31:0]          w_raw_hi, w_raw_lo;
  logic [63:0]          w_padded;
  logic [3:0]           w_bytes;
  logic [7:0]           w_mask;

  assign w_busy    = (r_state != S_IDLE);
  assign w_is_ad   = (r_state == S_AD);
  assign w_valid   = (r_state == S_AD) || (r_state == S_DATA);
  assign w_accept  = w_valid && bus.blk_ready_i;
  assign w_last    = (r_rem < 8'd8);
  assign w_host_we = !bus.mem_we_ni && !w_busy;
  assign w_clamp   = ({1'b0, bus.data_len_i} > c_data_max);
  assign w_dlen_c  = w_clamp ? c_data_max[7:0] : bus.data_len_i;

  // Pad blocks may index one block past the region; those read as zero.
  assign w_addr_hi = (w_is_ad ? c_aw'(c_ad_base) : c_data_base) + c_aw'({r_idx, 1'b0});
  assign w_addr_lo = w_addr_hi + c_aw'(1);
  assign w_raw_hi  = (w_addr_hi < c_total_a) ? r_buf[w_addr_hi[ADDR_W-1:0]] : 32'h0;
  assign w_raw_lo  = (w_addr_lo < c_total_a) ? r_buf[w_addr_lo[ADDR_W-1:0]] : 32'h0;

  ascon_pad_unit u_pad (
    .i_raw    ({w_raw_hi, w_raw_lo}),
    .i_rem    (r_rem),
    .o_padded (w_padded),
    .o_bytes  (w_bytes),
    .o_mask   (w_mask)
  );

  always_comb begin
    w_state_nx    = r_state;
    w_rem_nx      = r_rem;
    w_idx_nx      = r_idx;
    w_data_len_nx = r_data_len;
    w_len_err_nx  = r_len_err;
    w_wb_en       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start_i) begin
          w_len_err_nx  = w_clamp;
          w_data_len_nx = w_dlen_c;
          w_idx_nx      = '0;
          if (bus.ad_len_i != 5'd0) begin
            w_state_nx = S_AD;
            w_rem_nx   = {3'b000, bus.ad_len_i};
          end else begin
            w_state_nx = S_DATA;
            w_rem_nx   = w_dlen_c;
          end
        end
      end
      S_AD: begin
        if (w_accept) begin
          if (w_last) begin
            w_state_nx = S_DATA;
            w_rem_nx   = r_data_len;
            w_idx_nx   = '0;
          end else begin
            w_rem_nx   = r_rem - 8'd8;
            w_idx_nx   = r_idx + c_idx_w'(1);
          end
        end
      end
      S_DATA: begin
        if (w_accept) w_state_nx = S_WAIT_CT;
      end
      S_WAIT_CT: begin
        if (bus.ct_valid_i) begin
          w_wb_en = 1'b1;
          if (w_last) begin
            w_state_nx = S_DONE;
          end else begin
            w_state_nx = S_DATA;
            w_rem_nx   = r_rem - 8'd8;
            w_idx_nx   = r_idx + c_idx_w'(1);
          end
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state    <= S_IDLE;
      r_rem      <= '0;
      r_idx      <= '0;
      r_data_len <= '0;
      r_len_err  <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_rem      <= w_rem_nx;
      r_idx      <= w_idx_nx;
      r_data_len <= w_data_len_nx;
      r_len_err  <= w_len_err_nx;
      r_rdata    <= ({1'b0, bus.wb_addr_i} < c_total_a) ? r_buf[bus.wb_addr_i] : 32'h0;
    end
  end

  // Single write port: host writes only when idle, write-back only in WAIT_CT.
  always_ff @(posedge wb_clk_i) begin
    for (int w = 0; w < c_total; w++) begin
      for (int b = 0; b < 4; b++) begin
        if (w_host_we && ({1'b0, bus.wb_addr_i} == c_aw'(w)))
          r_buf[w][31-8*b -: 8] <= bus.wb_wdata_i[31-8*b -: 8];
        else if (w_wb_en && (w_addr_hi == c_aw'(w)) && w_mask[b])
          r_buf[w][31-8*b -: 8] <= bus.ct_data_i[63-8*b -: 8];
        else if (w_wb_en && (w_addr_lo == c_aw'(w)) && w_mask[4+b])
          r_buf[w][31-8*b -: 8] <= bus.ct_data_i[31-8*b -: 8];
      end
    end
  end

  assign bus.mem_rdata_o = r_rdata;
  assign bus.blk_valid_o = w_valid;
  assign bus.blk_data_o  = w_valid ? w_padded : 64'h0;
  assign bus.blk_is_ad_o = w_is_ad;
  assign bus.blk_last_o  = w_valid && w_last;
  assign bus.blk_bytes_o = w_valid ? w_bytes : 4'd0;
  assign bus.busy_o      = w_busy;
  assign bus.done_o      = (r_state == S_DONE);
  assign bus.len_err_o   = r_len_err;

endmodule

`default_nettype wire
